// File: rtl/sr32_seq_pkg.sv
// Shared definitions for the serial shifter family (right and left units).
// Holds the common FSM state encoding and the default data/shift widths
// so both units decode states and size their datapaths identically.
package sr32_seq_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SHW   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_e;

endpackage

// File: rtl/sr32_seq.sv
// Serial right shifter: one bit position per clock.
// A request (a, shamt, arith) is captured on an in_valid/in_ready handshake.
// The data register is then shifted right one bit per cycle, with the sign
// or zero fill entering at the MSB. The result is presented on out/out_valid
// until the consumer takes it with out_ready.
//
// Ports
//   clock     rising-edge clock
//   reset_n   synchronous active-low reset
//   in_valid  request present           in_ready  unit idle, can accept
//   a         operand                   shamt     right-shift amount
//   arith     1 = sign fill, 0 = zero fill
//   out_valid result present            out_ready consumer takes the result
//   out       shifted result, held between results
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for a request; in_ready high
// ST_SHIFT | shifting one bit per cycle until the counter reaches zero
// ST_DONE  | result on out, out_valid high until out_ready
module sr32_seq
  import sr32_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  shift_state_e     state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;

  // Gating with reset_n keeps in_ready low for the whole reset assertion,
  // and lets it rise on the first cycle after reset is released.
  assign in_ready  = reset_n && (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = a;
          cnt_d   = shamt;
          fill_d  = arith & a[WIDTH-1];
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cnt_q != '0) begin
          data_d = {fill_q, data_q[WIDTH-1:1]};
          cnt_d  = cnt_q - CNT_ONE;
        end else begin
          // A separate output register keeps out at the previous result
          // while the working register is still shifting.
          out_d       = data_q;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        // A request arriving on the completing edge waits for IDLE,
        // because in_ready is low here.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      fill_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_sr32_seq.sv
// Bench for sr32_seq: a cycle-level behavioural model (a latency countdown
// plus the arithmetic result) is compared against the DUT on every cycle.
// Directed requests pin the model with literal results and latencies, then
// a randomized back-to-back stream with random output stalls follows.
module tb_sr32_seq;

  localparam int W = 32;
  localparam int S = 5;
  localparam int N_RAND = 1000;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [S-1:0] shamt = '0;
  logic         arith = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // behavioural model
  bit           m_busy  = 1'b0;
  bit           m_valid = 1'b0;
  int           m_left  = 0;
  logic [W-1:0] m_res   = '0;
  logic [W-1:0] m_out   = '0;

  bit run_cons = 1'b0;
  int done_cnt = 0;

  always #5 clock = ~clock;

  sr32_seq #(.WIDTH(W), .SHW(S)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shamt     (shamt),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input int sh, input bit ar);
    logic signed [W-1:0] sv;
    sv = v;
    if (ar) return sv >>> sh;
    return v >> sh;
  endfunction

  // Model update on the edge, then compare #1 later against the DUT.
  always @(posedge clock) begin
    cyc++;
    if (!reset_n) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_out   = '0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy  = 1'b0;
        m_valid = 1'b1;
        m_out   = m_res;
      end
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (in_valid) begin
      m_busy = 1'b1;
      m_left = int'(shamt) + 1;
      m_res  = ref_shift(a, int'(shamt), arith);
    end
    #1;
    check("model out_valid", W'(out_valid), W'(m_valid));
    check("model out", out, m_out);
    check("model in_ready", W'(in_ready), W'(reset_n && !m_busy && !m_valid));
  end

  task automatic do_req(input string name, input logic [W-1:0] av, input logic [S-1:0] sv,
                        input bit ar, input logic [W-1:0] exp_out, input int exp_lat,
                        input int hold, input bit zap);
    int t;
    int acc;
    @(negedge clock);
    in_valid = 1'b1; a = av; shamt = sv; arith = ar; out_ready = 1'b0;
    t = 0;
    while (!in_ready && t < 100) begin @(negedge clock); t++; end
    if (!in_ready) begin
      check({name, " accept timeout"}, W'(in_ready), W'(1));
      in_valid = 1'b0;
      return;
    end
    @(negedge clock);
    acc = cyc;
    in_valid = 1'b0;
    if (zap) begin a = '0; shamt = S'($urandom); arith = ~ar; end
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clock); t++; end
    check({name, " latency"}, W'(cyc - acc), W'(exp_lat));
    check({name, " out"}, out, exp_out);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check({name, " held valid"}, W'(out_valid), W'(1));
      check({name, " held out"}, out, exp_out);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check({name, " released"}, W'(out_valid), W'(0));
  endtask

  initial begin
    int t;
    bit stale;

    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset out_valid", W'(out_valid), W'(0));
    check("reset out", out, '0);
    check("reset in_ready", W'(in_ready), W'(0));
    reset_n = 1'b1;
    #1;
    check("in_ready after reset", W'(in_ready), W'(1));

    do_req("sh0",      32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 1,  5, 1'b0);
    do_req("lsr31",    32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 32, 0, 1'b0);
    do_req("asr31",    32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 32, 0, 1'b0);
    do_req("asr4 zap", 32'hF0F0_F0F0, 5'd4,  1'b1, 32'hFF0F_0F0F, 5,  2, 1'b1);
    do_req("lsr4",     32'hF0F0_F0F0, 5'd4,  1'b0, 32'h0F0F_0F0F, 5,  0, 1'b0);

    // reset in the middle of SHIFT
    @(negedge clock);
    in_valid = 1'b1; a = 32'hDEAD_BEEF; shamt = 5'd20; arith = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin @(negedge clock); t++; end
    @(negedge clock);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("mid-shift reset out_valid", W'(out_valid), W'(0));
    check("mid-shift reset out", out, '0);
    check("mid-shift reset in_ready", W'(in_ready), W'(1));
    stale = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (out_valid) stale = 1'b1;
    end
    check("no stale result", W'(stale), W'(0));

    // randomized back-to-back stream with random consumer stalls
    run_cons = 1'b1;
    fork
      begin
        for (int i = 0; i < N_RAND; i++) begin
          @(negedge clock);
          if ($urandom_range(0, 5) == 0) begin
            in_valid = 1'b0;
            @(negedge clock);
          end
          in_valid = 1'b1;
          a = $urandom;
          shamt = S'($urandom);
          arith = 1'($urandom);
          t = 0;
          while (!in_ready && t < 300) begin
            @(negedge clock);
            t++;
            if (t == 3) a = $urandom;
          end
          if (!in_ready) begin
            check("random accept timeout", W'(in_ready), W'(1));
            break;
          end
        end
        @(negedge clock);
        in_valid = 1'b0;
        t = 0;
        while (done_cnt < N_RAND && t < 1000) begin @(negedge clock); t++; end
        run_cons = 1'b0;
      end
      begin
        while (run_cons) begin
          @(negedge clock);
          out_ready = ($urandom_range(0, 2) != 0);
          if (out_valid && out_ready) done_cnt++;
        end
        out_ready = 1'b0;
      end
    join
    check("random completions", W'(done_cnt), W'(N_RAND));

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
